// File: rtl/axi_stream_guard_pkg.sv
// Shared types and helpers for the AXI-Stream packet length guard.
package axi_stream_guard_pkg;

    localparam int unsigned TRUNC_CNT_W = 16;

    typedef enum logic {
        PASS    = 1'b0,
        DISCARD = 1'b1
    } guard_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [TRUNC_CNT_W-1:0] sat_inc(input logic [TRUNC_CNT_W-1:0] value);
        return (value == '1) ? value : value + TRUNC_CNT_W'(1);
    endfunction

endpackage

// File: rtl/axi_stream_packet_length_guard_skid_slice.sv
// Two-entry registered AXI-Stream slice: full throughput, registered ready,
// one cycle of latency when the output register is free.
module axis_skid_slice #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] out_data_n;
    logic         out_valid_n;
    logic [W-1:0] skid_data;
    logic [W-1:0] skid_data_n;
    logic         skid_valid;
    logic         skid_valid_n;
    logic         in_acc_c;
    logic         out_xfer_c;

    assign in_acc_c   = in_valid && in_ready;
    assign out_xfer_c = out_valid && out_ready;

    // Output register refills from the skid first so order is preserved.
    always_comb begin
        out_data_n   = out_data;
        out_valid_n  = out_valid;
        skid_data_n  = skid_data;
        skid_valid_n = skid_valid;
        if (!out_valid || out_xfer_c) begin
            if (skid_valid) begin
                out_data_n   = skid_data;
                out_valid_n  = 1'b1;
                skid_valid_n = 1'b0;
            end else if (in_acc_c) begin
                out_data_n  = in_data;
                out_valid_n = 1'b1;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (in_acc_c) begin
            skid_data_n  = in_data;
            skid_valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            out_data   <= out_data_n;
            out_valid  <= out_valid_n;
            skid_data  <= skid_data_n;
            skid_valid <= skid_valid_n;
            in_ready   <= !skid_valid_n;
        end
    end

endmodule

// File: rtl/axi_stream_packet_length_guard.sv
// Caps every packet at MAX_LEN beats: forces tlast on the last allowed beat
// and swallows the remainder of the original packet up to its tlast.
module axi_stream_packet_length_guard
    import axi_stream_guard_pkg::*;
#(
    parameter int unsigned DSIZE   = 8,
    parameter int unsigned MAX_LEN = 8096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DSIZE-1:0]       s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [DSIZE-1:0]       m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   trunc_pulse,
    output logic [TRUNC_CNT_W-1:0] trunc_count,
    output logic                   in_discard
);

    localparam int unsigned CW       = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);

    guard_state_t  state;
    guard_state_t  state_n;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_cnt_n;
    logic          s_acc_c;
    logic          fwd_valid_c;
    logic          fwd_last_c;
    logic          trunc_hit_c;
    logic          slice_ready;
    logic [DSIZE:0] slice_out;

    // Discarding never waits on the downstream; forwarding waits on the skid.
    assign s_axis_tready = (state == DISCARD) || slice_ready;
    assign s_acc_c       = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_n     = state;
        beat_cnt_n  = beat_cnt;
        fwd_valid_c = 1'b0;
        fwd_last_c  = s_axis_tlast;
        trunc_hit_c = 1'b0;
        case (state)
            PASS: begin
                fwd_valid_c = s_axis_tvalid;
                if (beat_cnt == LAST_IDX) begin
                    fwd_last_c = 1'b1;
                end
                if (s_acc_c) begin
                    if (s_axis_tlast) begin
                        beat_cnt_n = '0;
                    end else if (beat_cnt == LAST_IDX) begin
                        beat_cnt_n  = '0;
                        trunc_hit_c = 1'b1;
                        state_n     = DISCARD;
                    end else begin
                        beat_cnt_n = beat_cnt + CW'(1);
                    end
                end
            end
            DISCARD: begin
                if (s_acc_c && s_axis_tlast) begin
                    state_n    = PASS;
                    beat_cnt_n = '0;
                end
            end
            default: begin
                state_n    = PASS;
                beat_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PASS;
            beat_cnt    <= '0;
            trunc_pulse <= 1'b0;
            trunc_count <= '0;
            in_discard  <= 1'b0;
        end else begin
            state       <= state_n;
            beat_cnt    <= beat_cnt_n;
            trunc_pulse <= trunc_hit_c;
            in_discard  <= (state_n == DISCARD);
            if (trunc_hit_c) begin
                trunc_count <= sat_inc(trunc_count);
            end
        end
    end

    axis_skid_slice #(
        .W (DSIZE + 1)
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({fwd_last_c, s_axis_tdata}),
        .in_valid  (fwd_valid_c),
        .in_ready  (slice_ready),
        .out_data  (slice_out),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    assign m_axis_tlast = slice_out[DSIZE];
    assign m_axis_tdata = slice_out[DSIZE-1:0];

endmodule
